// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and the reciprocal factor table for recip_divider.
package div_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned VW      = 8;
  localparam int unsigned MAX_DIV = 30;

  typedef struct packed {
    logic [15:0] mul;
    logic [4:0]  shift;
  } factor_t;

  typedef factor_t [31:0] factor_tab_t;

  typedef enum logic [2:0] {StIdle, StMul, StCheck, StFix, StHold} state_e;

  // Unsupported divisors map to the identity factor; the FSM flags them separately.
  function automatic factor_t factor_of(int unsigned d);
    factor_t f;
    f.mul   = 16'd1;
    f.shift = 5'd0;
    if (d != 0 && d <= MAX_DIV) begin
      if ((d & (d - 1)) == 0) begin
        for (int unsigned s = 0; s < 5; s++) begin
          if ((32'd1 << s) == d) f.shift = 5'(s);
        end
      end else if (d == 3) begin
        f.mul   = 16'd21845;
        f.shift = 5'd16;
      end else begin
        f.mul   = 16'((32'd131072 + d) / (2 * d));
        f.shift = 5'd16;
      end
    end
    return f;
  endfunction

  function automatic factor_tab_t build_factor_tab();
    factor_tab_t t;
    for (int unsigned d = 0; d < 32; d++) begin
      t[5'(d)] = factor_of(d);
    end
    return t;
  endfunction

  localparam factor_tab_t FACTOR_TAB = build_factor_tab();

endpackage

// File: rtl/serial_mul16.sv
// 16x16 shift-add multiplier: one multiplier bit per cycle, done pulses on the 16th step.
module serial_mul16 (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        done_o,
  output logic [31:0] prod_o
);

  logic [31:0] acc_q, acc_d;
  logic [31:0] a_sh_q, a_sh_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  always_comb begin
    acc_d  = acc_q;
    a_sh_d = a_sh_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      acc_d  = '0;
      a_sh_d = {16'b0, a_i};
      b_d    = b_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_q[0]) acc_d = acc_q + a_sh_q;
      a_sh_d = a_sh_q << 1;
      b_d    = b_q >> 1;
      cnt_d  = cnt_q + 4'd1;
      if (cnt_q == 4'd15) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_sh_q <= a_sh_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == 4'd15);
  assign prod_o = acc_q;

endmodule

// File: rtl/recip_divider.sv
// Floor divider by 1..30 using a reciprocal multiply-and-shift plus a single +/-1 correction.
module recip_divider import div_pkg::*; (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] quotient_o,
  output logic [VW-1:0] remainder_o,
  output logic          err_o
);

  state_e              state_q, state_d;
  logic [DW-1:0]       dividend_q, dividend_d;
  logic [VW-1:0]       divisor_q, divisor_d;
  logic [4:0]          shift_q, shift_d;
  logic                bad_q, bad_d;
  logic [DW-1:0]       q0_q, q0_d;
  logic signed [17:0]  r_q, r_d;
  logic [DW-1:0]       quot_q, quot_d;
  logic [VW-1:0]       rem_q, rem_d;
  logic                err_q, err_d;

  logic                mul_start, mul_done;
  logic [31:0]         prod;
  factor_t             factor_in;
  logic                bad_in;
  logic [DW-1:0]       q0_c;
  logic [23:0]         qd;
  logic signed [24:0]  r_wide;

  serial_mul16 u_mul (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (dividend_i),
    .b_i     (factor_in.mul),
    .done_o  (mul_done),
    .prod_o  (prod)
  );

  always_comb begin
    bad_in    = (divisor_i == '0) || (divisor_i > VW'(MAX_DIV));
    factor_in = bad_in ? '{mul: 16'd1, shift: 5'd0} : FACTOR_TAB[divisor_i[4:0]];
    q0_c      = DW'(prod >> shift_q);
    qd        = {8'b0, q0_c} * {16'b0, divisor_q};
    r_wide    = $signed({9'b0, dividend_q}) - $signed({1'b0, qd});
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    shift_d    = shift_q;
    bad_d      = bad_q;
    q0_d       = q0_q;
    r_d        = r_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    err_d      = err_q;
    mul_start  = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          mul_start  = 1'b1;
          dividend_d = dividend_i;
          divisor_d  = divisor_i;
          shift_d    = factor_in.shift;
          bad_d      = bad_in;
          state_d    = StMul;
        end
      end
      StMul: if (mul_done) state_d = StCheck;
      StCheck: begin
        q0_d    = q0_c;
        r_d     = r_wide[17:0];
        state_d = StFix;
      end
      StFix: begin
        err_d = bad_q;
        if (bad_q) begin
          quot_d = 16'hFFFF;
          rem_d  = '0;
        end else if (r_q[17]) begin
          quot_d = q0_q - 16'd1;
          rem_d  = r_q[7:0] + divisor_q;
        end else if (r_q[16:0] >= {9'b0, divisor_q}) begin
          quot_d = q0_q + 16'd1;
          rem_d  = r_q[7:0] - divisor_q;
        end else begin
          quot_d = q0_q;
          rem_d  = r_q[7:0];
        end
        state_d = StHold;
      end
      StHold: if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      divisor_q  <= '0;
      shift_q    <= '0;
      bad_q      <= 1'b0;
      q0_q       <= '0;
      r_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      shift_q    <= shift_d;
      bad_q      <= bad_d;
      q0_q       <= q0_d;
      r_q        <= r_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StHold);
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_recip_divider.sv
// Scoreboard bench for recip_divider: random and directed requests against an arithmetic model.
module tb_recip_divider;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   checked = 0;
  int   rdy_mode = 0;
  exp_t sb[$];

  recip_divider dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .err_o       (err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] d);
    exp_t x;
    if (d == 0 || d > 30) begin
      x.q = 16'hFFFF;
      x.r = 8'd0;
      x.e = 1'b1;
    end else begin
      x.q = 16'(int'(a) / int'(d));
      x.r = 8'(int'(a) % int'(d));
      x.e = 1'b0;
    end
    return x;
  endfunction

  // Monitor: compares the first cycle of each presented result, pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      checked = 0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc + 1;
      if (out_valid && !checked) begin
        checked = 1;
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          check("quotient", 32'(quotient), 32'(sb[0].q));
          check("remainder", 32'(remainder), 32'(sb[0].r));
          check("err", 32'(err), 32'(sb[0].e));
          check("latency", 32'(cyc - acc_cyc), 32'd18);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        checked = 0;
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [7:0] d);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    sb.push_back(model(a, d));
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    dividend = a;
    divisor  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] hq;
    logic [7:0]  hr;
    logic        he;
    int          g;

    #2 rst_n = 1'b0;
    #20;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: no correction, upward, downward, powers of two, max, error path.
    send(16'd100, 8'd7);
    send(16'd3, 8'd3);
    send(16'd32771, 8'd6);
    send(16'd1000, 8'd8);
    send(16'd65535, 8'd30);
    send(16'd65535, 8'd1);
    send(16'd4321, 8'd0);
    send(16'd4321, 8'd31);
    send(16'd50, 8'd5);
    send(16'd0, 8'd29);
    drain();

    // Random with random backpressure; roughly one in eight divisors is out of range.
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) send(16'($urandom), 8'($urandom_range(31, 255)));
      else send(16'($urandom), 8'($urandom_range(1, 30)));
    end
    drain();

    // Backpressure hold; in_valid stays high with junk while busy and while holding.
    rdy_mode = 2;
    send(16'd12345, 8'd11);
    #1;
    in_valid = 1'b1;
    dividend = 16'd999;
    divisor  = 8'd3;
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    hq = quotient;
    hr = remainder;
    he = err;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_q", 32'(quotient), 32'(hq));
      check("bp_hold_r", 32'(remainder), 32'(hr));
      check("bp_hold_err", 32'(err), 32'(he));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 0;
    out_ready = 1'b1;
    drain();
    repeat (25) @(posedge clk);

    // Reset at E8 of a fresh operation: result must never appear.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    dividend = 16'd5000;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    send(16'd777, 8'd13);
    send(16'd40000, 8'd24);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/recip_divider.md
Name: recip_divider

Overview:
- Sequential integer divider: 16-bit dividend by 8-bit divisor (1..30) using reciprocal multiply-and-shift. Returns an exact floor quotient and remainder.
- Consumes the same reciprocal factor set (mul/shift pairs) as the team's divisor factor lookup.
- Adds the serial product, the remainder check and the ±1 correction that a bare multiply-and-shift lacks.
- Used by the averaging and scaling paths on the DE2_115 master.

Parameters:
- DW, 16, dividend and quotient width (fixed; not to be overridden).
- VW, 8, divisor width (fixed).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block idle and can accept.
- dividend  in  16  numerator.
- divisor  in  8  denominator; 1..30 supported.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  16  floor(dividend/divisor).
- remainder  out  8  dividend mod divisor.
- err  out  1  divisor outside 1..30.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1, out_valid=0.
  - quotient=0, remainder=0, err=0.
  - All internal registers cleared.
  - Reset at any point aborts the operation in flight; no partial result is ever presented.
- Accept: edge E0 where in_valid && in_ready. Latch dividend, divisor, and the mul/shift factor for divisor. in_ready=0 from E0 until return to IDLE.
- Factor rule:
  - Powers of two: mul=1, shift=log2(d).
  - Others: shift=16, mul=round(65536/d).
  - Exception: d=3 uses mul=21845.
  - Divisor 0 or >30 selects mul=1, shift=0, err path.
- MUL state (E1..E16): shift-add product P[31:0]=dividend*mul, one mul bit per cycle, 4-bit counter 0..15.
- CHECK state (E17):
  - q0 = P>>shift (16 bits).
  - Register signed 18-bit r = dividend - q0*divisor. Single combinational 16x8 multiply allowed here.
- FIX state (E18): register results and set out_valid=1.
  - r<0: quotient=q0-1, remainder=r+divisor.
  - r>=divisor: quotient=q0+1, remainder=r-divisor.
  - Otherwise: quotient=q0, remainder=r.
- Latency: out_valid rises exactly 18 edges after E0, for every divisor.
- Error path: still takes 18 cycles. FIX forces quotient=16'hFFFF, remainder=0, err=1.
- HOLD state:
  - quotient, remainder, err and out_valid stay stable until out_valid && out_ready.
  - On that edge: out_valid=0, state=IDLE, in_ready=1.
  - quotient, remainder and err keep their last values.
- No overlap: the next request is accepted no earlier than the edge after the result handshake.
- Inputs are ignored outside IDLE; in_valid while busy has no effect.
- Error bound: |q0 - floor(dividend/d)| <= 1 for all supported d, so a single correction step is sufficient.

Decomposition:
- Package div_pkg:
  - width constants DW, VW.
  - Factor table as a constant function mapping divisor to {mul[15:0], shift[4:0]}.
  - MAX_DIV=30.
  - State enum IDLE/MUL/CHECK/FIX/HOLD.
- One sub-module, serial_mul16: 16x16 shift-add multiplier with start, 16-cycle busy, and a done pulse on the last cycle. The top-level FSM sequences it.

Test Plan:
- 100/7 -> q0=14, r=2, no correction. Expect quotient=14, remainder=2, err=0, out_valid 18 cycles after accept.
- 3/3 (mul=21845 truncated) -> q0=0, r=3. Expect upward correction: quotient=1, remainder=0.
- 32771/6 -> q0=5462, r=-1. Expect downward correction: quotient=5461, remainder=5.
- 1000/8 (power of two, shift=3) -> quotient=125, remainder=0. Also 65535/30 -> quotient=2184, remainder=15.
- Divisor 0, then divisor 31 -> each gives err=1, quotient=16'hFFFF, remainder=0 after 18 cycles. A following valid request gives err=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, in_valid pulses ignored.
  - Assert rst_n=0 at E8 of a new operation: in_ready=1 and out_valid=0 immediately. Next request completes correctly.
